// File: rtl/uart_pkg.sv
// Shared encodings for the configurable UART transmitter: parity modes, FSM states,
// and the width helper for the per-frame bit counter.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Counter must index DATA_BITS payload bits; a 1-bit floor keeps tiny widths legal
  function automatic int bit_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_cfg_if.sv
// Host-side byte handshake: send acts as valid, ready is high whenever the FIFO is not full.
// A byte is taken on any clk edge where send && ready; send && !ready is dropped.
interface uart_tx_fifo_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_in;
  logic                 send;
  logic                 ready;

  modport master (output data_in, output send, input ready);
  modport slave  (input data_in, input send, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO, zero-latency head read; pushes while full and pops while empty are ignored.
// A separate occupancy count tells full from empty since the pointers wrap modulo DEPTH.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// Configurable UART transmitter fed by a FIFO; start bit appears 1 clk after the first baud_tick
// following a push, frames run back-to-back while data is queued; ready = !full.
module uart_tx_fifo_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  uart_tx_fifo_cfg_if.slave               host,
  input  logic                            baud_tick,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
  localparam int CW = bit_cnt_w(DATA_BITS);

  state_t               state;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] head;
  logic [CW-1:0]        cnt;
  logic                 par;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 last_stop;
  logic                 pop;

  assign last_stop  = (state == S_STOP) && (cnt == CW'(STOP_BITS - 1));
  assign pop        = baud_tick && !fifo_empty && ((state == S_IDLE) || last_stop);
  assign host.ready = !fifo_full;
  assign busy       = (state != S_IDLE) || !fifo_empty;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (host.send),
    .pop   (pop),
    .din   (host.data_in),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      tx    <= 1'b1;
      shift <= '0;
      cnt   <= '0;
      par   <= 1'b0;
    end else if (baud_tick) begin
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            shift <= head;
            par   <= (PARITY == PARITY_ODD) ? ~^head : ^head;
            tx    <= 1'b0;
            state <= S_START;
          end
        end
        S_START: begin
          tx    <= shift[0];
          shift <= shift >> 1;
          cnt   <= '0;
          state <= S_DATA;
        end
        S_DATA: begin
          if (cnt == CW'(DATA_BITS - 1)) begin
            cnt <= '0;
            if (PARITY != PARITY_NONE) begin
              tx    <= par;
              state <= S_PARITY;
            end else begin
              tx    <= 1'b1;
              state <= S_STOP;
            end
          end else begin
            tx    <= shift[0];
            shift <= shift >> 1;
            cnt   <= cnt + CW'(1);
          end
        end
        S_PARITY: begin
          tx    <= 1'b1;
          cnt   <= '0;
          state <= S_STOP;
        end
        S_STOP: begin
          // Queued data skips IDLE so the next start bit follows the stop bit directly
          if (last_stop) begin
            if (pop) begin
              shift <= head;
              par   <= (PARITY == PARITY_ODD) ? ~^head : ^head;
              tx    <= 1'b0;
              state <= S_START;
            end else begin
              tx    <= 1'b1;
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Directed bench: four transmitter configurations sharing clk/reset/baud_tick, one tick per 10 clks;
// tx is sampled 1 time unit after each tick edge and compared against hand-built frames.
module tb_uart_tx_fifo_cfg;

  logic clk = 1'b0;
  logic reset;
  logic baud_tick;

  always #5 clk = ~clk;

  uart_tx_fifo_cfg_if #(.DATA_BITS(8)) h0 ();
  uart_tx_fifo_cfg_if #(.DATA_BITS(8)) h1 ();
  uart_tx_fifo_cfg_if #(.DATA_BITS(8)) h2 ();
  uart_tx_fifo_cfg_if #(.DATA_BITS(7)) h3 ();

  logic       tx0, tx1, tx2, tx3;
  logic       busy0, busy1, busy2, busy3;
  logic [2:0] lvl0, lvl1, lvl2, lvl3;

  uart_tx_fifo_cfg d0 (
    .clk(clk), .reset(reset), .host(h0), .baud_tick(baud_tick),
    .tx(tx0), .busy(busy0), .fifo_level(lvl0)
  );
  uart_tx_fifo_cfg #(.PARITY(2)) d1 (
    .clk(clk), .reset(reset), .host(h1), .baud_tick(baud_tick),
    .tx(tx1), .busy(busy1), .fifo_level(lvl1)
  );
  uart_tx_fifo_cfg #(.PARITY(1)) d2 (
    .clk(clk), .reset(reset), .host(h2), .baud_tick(baud_tick),
    .tx(tx2), .busy(busy2), .fifo_level(lvl2)
  );
  uart_tx_fifo_cfg #(.DATA_BITS(7), .STOP_BITS(2)) d3 (
    .clk(clk), .reset(reset), .host(h3), .baud_tick(baud_tick),
    .tx(tx3), .busy(busy3), .fifo_level(lvl3)
  );

  int          total = 0;
  int          bad   = 0;
  logic [63:0] v0, v1, v2, v3;
  logic [2:0]  lvl0_first;
  logic        rdy0_first;
  logic [2:0]  max_lvl0 = '0;
  logic [7:0]  msg [4] = '{8'h53, 8'h45, 8'h4E, 8'h44};

  always @(negedge clk) if (lvl0 > max_lvl0) max_lvl0 = lvl0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_period();
    baud_tick = 1'b0;
    repeat (9) step();
    baud_tick = 1'b1;
    step();
    baud_tick = 1'b0;
  endtask

  task automatic run_bits(input int n);
    v0 = '0; v1 = '0; v2 = '0; v3 = '0;
    for (int i = 0; i < n; i++) begin
      bit_period();
      v0[i] = tx0; v1[i] = tx1; v2[i] = tx2; v3[i] = tx3;
      if (i == 0) begin
        lvl0_first = lvl0;
        rdy0_first = h0.ready;
      end
    end
  endtask

  function automatic logic [9:0] f8n1(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  initial begin
    reset = 1'b1;
    baud_tick = 1'b0;
    h0.send = 1'b0; h1.send = 1'b0; h2.send = 1'b0; h3.send = 1'b0;
    h0.data_in = '0; h1.data_in = '0; h2.data_in = '0; h3.data_in = '0;
    step(); step();
    chk("rst_tx", 32'(tx0), 1);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_ready", 32'(h0.ready), 1);
    chk("rst_level", 32'(lvl0), 0);
    reset = 1'b0;
    step();

    // 8N1 single byte
    h0.data_in = 8'h53; h0.send = 1'b1;
    step();
    h0.send = 1'b0;
    chk("push_level", 32'(lvl0), 1);
    chk("push_busy", 32'(busy0), 1);
    run_bits(10);
    chk("8n1_frame", 32'(v0[9:0]), 32'h2A6);
    chk("8n1_busy_in_stop", 32'(busy0), 1);
    bit_period();
    chk("8n1_busy_end", 32'(busy0), 0);
    chk("8n1_idle_tx", 32'(tx0), 1);

    // even and odd parity on 0x53
    h1.data_in = 8'h53; h1.send = 1'b1;
    h2.data_in = 8'h53; h2.send = 1'b1;
    step();
    h1.send = 1'b0; h2.send = 1'b0;
    run_bits(11);
    chk("even_frame", 32'(v1[10:0]), 32'h4A6);
    chk("odd_frame", 32'(v2[10:0]), 32'h6A6);
    bit_period();
    chk("even_busy_end", 32'(busy1), 0);
    chk("odd_busy_end", 32'(busy2), 0);

    // 7 data bits, 2 stop bits
    h3.data_in = 7'h7F; h3.send = 1'b1;
    step();
    h3.send = 1'b0;
    run_bits(10);
    chk("7n2_frame", 32'(v3[9:0]), 32'h3FE);
    chk("7n2_busy_2nd_stop", 32'(busy3), 1);
    bit_period();
    chk("7n2_busy_end", 32'(busy3), 0);
    chk("7n2_idle_tx", 32'(tx3), 1);

    // fill FIFO with "SEND", then a fifth byte that must be dropped
    for (int i = 0; i < 4; i++) begin
      h0.data_in = msg[i]; h0.send = 1'b1;
      step();
    end
    chk("full_level", 32'(lvl0), 4);
    chk("full_ready", 32'(h0.ready), 0);
    h0.data_in = 8'h58;
    step();
    h0.send = 1'b0;
    chk("drop_level", 32'(lvl0), 4);
    run_bits(40);
    chk("pop1_level", 32'(lvl0_first), 3);
    chk("pop1_ready", 32'(rdy0_first), 1);
    for (int k = 0; k < 4; k++)
      chk($sformatf("send_frame%0d", k), 32'(v0[k*10 +: 10]), 32'(f8n1(msg[k])));
    bit_period();
    chk("send_busy_end", 32'(busy0), 0);
    chk("send_idle_tx", 32'(tx0), 1);
    chk("max_level", 32'(max_lvl0), 4);

    // reset in the middle of a data bit
    h0.data_in = 8'h53; h0.send = 1'b1;
    step();
    h0.data_in = 8'h41;
    step();
    h0.send = 1'b0;
    bit_period(); bit_period(); bit_period(); bit_period();
    chk("mid_tx_bit2", 32'(tx0), 0);
    chk("mid_level", 32'(lvl0), 1);
    reset = 1'b1;
    step();
    chk("abort_tx", 32'(tx0), 1);
    chk("abort_busy", 32'(busy0), 0);
    chk("abort_level", 32'(lvl0), 0);
    reset = 1'b0;

    // push on the same edge as an IDLE tick: frame waits for the next tick
    h0.data_in = 8'h53; h0.send = 1'b1; baud_tick = 1'b1;
    step();
    h0.send = 1'b0; baud_tick = 1'b0;
    chk("same_tick_tx", 32'(tx0), 1);
    chk("same_tick_level", 32'(lvl0), 1);
    run_bits(10);
    chk("clean_frame", 32'(v0[9:0]), 32'h2A6);
    bit_period();
    chk("clean_busy_end", 32'(busy0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
